// File: rtl/autocorr_pkg.sv
// autocorr_pkg: shared FSM encoding and width helpers for auto_corr.
package autocorr_pkg;
  typedef enum logic [1:0] {IDLE, FILL, CALC, DONE} state_e;
  localparam int PERIOD_W = 16;
  function automatic int acc_w(input int dw, input int max_tau);
    return 2 * dw + $clog2(max_tau) + 1;
  endfunction
  // lag counter must hold 0..max_tau inclusive
  function automatic int lag_w(input int max_tau);
    return $clog2(max_tau) + 1;
  endfunction
  // write counter must hold 0..2*max_tau inclusive
  function automatic int cnt_w(input int max_tau);
    return $clog2(max_tau) + 2;
  endfunction
endpackage

// File: rtl/autocorr_buf.sv
// autocorr_buf: frame RAM, one write port and two registered read ports (latency 1).
module autocorr_buf #(
  parameter int DW    = 12,
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  input  logic [AW-1:0] ra_i,
  input  logic [AW-1:0] rb_i,
  output logic [DW-1:0] qa_o,
  output logic [DW-1:0] qb_o
);
  logic [DW-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wa_i] <= wd_i;
    qa_o <= mem_q[ra_i];
    qb_o <= mem_q[rb_i];
  end
endmodule

// File: rtl/auto_corr.sv
// auto_corr: frame-based autocorrelation period detector (FILL frame, MAC all lags, pick peak).
// Optional AUTOCORR_CONFIRM_EN: a new nonzero period loads only if within +/-1 of the previous frame result.
module auto_corr
  import autocorr_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int MAX_TAU    = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         adc_clk,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         stable,
  output logic [PERIOD_W-1:0]          period
);
  localparam int ACC_W = acc_w(DATA_WIDTH, MAX_TAU);
  localparam int LW    = lag_w(MAX_TAU);
  localparam int CW    = cnt_w(MAX_TAU);
  localparam int AW    = $clog2(2 * MAX_TAU);
  localparam int NW    = $clog2(MAX_TAU);

  state_e state_q, state_d;
  logic [2:0] sync_q;
  logic strike, we, run, iss, last_res;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [NW-1:0] n_q, n_d;
  logic [LW-1:0] tau_q, tau_d, rtau_q, rtau_d;
  logic [AW-1:0] ra, rb;
  logic signed [DATA_WIDTH-1:0] qa, qb;
  logic v1_q, f1_q, l1_q, v2_q, f2_q, l2_q;
  logic signed [2*DATA_WIDTH-1:0] prod_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, sum;
  logic neg_q, neg_d, pk_v_q, pk_v_d;
  logic signed [ACC_W-1:0] pk_q, pk_d;
  logic [LW-1:0] pk_lag_q, pk_lag_d;
  logic [PERIOD_W-1:0] res, period_q, period_d;

  // sync_q[1:0] is the 2-flop synchronizer, sync_q[2] the edge-detect history
  assign strike = sync_q[1] & ~sync_q[2];
  assign we = state_q == FILL && strike && en && wr_cnt_q != CW'(2 * MAX_TAU);
  assign run = state_q == CALC && stable;
  assign iss = run && tau_q <= LW'(MAX_TAU);
  assign ra = AW'(n_q);
  assign rb = AW'(n_q) + AW'(tau_q);
  assign last_res = v2_q && l2_q && rtau_q == LW'(MAX_TAU);

  autocorr_buf #(.DW(DATA_WIDTH), .DEPTH(2 * MAX_TAU), .AW(AW)) u_buf (
    .clk (clk),
    .we_i(we),
    .wa_i(wr_cnt_q[AW-1:0]),
    .wd_i(data_in),
    .ra_i(ra),
    .rb_i(rb),
    .qa_o(qa),
    .qb_o(qb)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = stable ? FILL : IDLE;
      FILL:    state_d = !stable ? IDLE : (wr_cnt_q == CW'(2 * MAX_TAU)) ? CALC : FILL;
      CALC:    state_d = !stable ? IDLE : last_res ? DONE : CALC;
      default: state_d = stable ? FILL : IDLE;
    endcase
  end

  assign wr_cnt_d = (state_q == FILL && stable) ? wr_cnt_q + CW'(we) : '0;
  // n wraps naturally at MAX_TAU (power of two), stepping tau once per lag
  assign n_d = !run ? '0 : iss ? n_q + NW'(1) : n_q;
  assign tau_d = !run ? '0 : (iss && n_q == NW'(MAX_TAU - 1)) ? tau_q + LW'(1) : tau_q;
  assign sum = (f2_q ? ACC_W'(0) : acc_q) + ACC_W'(prod_q);
  assign acc_d = !run ? '0 : v2_q ? sum : acc_q;
  assign rtau_d = !run ? '0 : (v2_q && l2_q) ? rtau_q + LW'(1) : rtau_q;

  always_comb begin
    neg_d = neg_q;
    pk_v_d = pk_v_q;
    pk_d = pk_q;
    pk_lag_d = pk_lag_q;
    if (!run) begin
      neg_d = 1'b0;
      pk_v_d = 1'b0;
      pk_d = '0;
      pk_lag_d = '0;
    end else if (v2_q && l2_q) begin
      if (neg_q && (!pk_v_q || sum > pk_q)) begin
        pk_v_d = 1'b1;
        pk_d = sum;
        pk_lag_d = rtau_q;
      end
      if (!neg_q && rtau_q != '0 && sum < 0) neg_d = 1'b1;
    end
  end

  assign res = (pk_v_q && pk_q > 0) ? PERIOD_W'(pk_lag_q) : '0;

`ifdef AUTOCORR_CONFIRM_EN
  logic [PERIOD_W-1:0] prev_q;
  logic near;
  assign near = (res + PERIOD_W'(1) >= prev_q) && (res <= prev_q + PERIOD_W'(1));
  assign period_d = (state_q == DONE && (res == '0 || near)) ? res : period_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else if (state_q == DONE) prev_q <= res;
  end
`else
  assign period_d = state_q == DONE ? res : period_q;
`endif

  assign period = period_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q <= '0;
      wr_cnt_q <= '0;
      n_q <= '0;
      tau_q <= '0;
      rtau_q <= '0;
      v1_q <= 1'b0;
      f1_q <= 1'b0;
      l1_q <= 1'b0;
      v2_q <= 1'b0;
      f2_q <= 1'b0;
      l2_q <= 1'b0;
      prod_q <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
      pk_v_q <= 1'b0;
      pk_q <= '0;
      pk_lag_q <= '0;
      period_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[1:0], adc_clk};
      wr_cnt_q <= wr_cnt_d;
      n_q <= n_d;
      tau_q <= tau_d;
      rtau_q <= rtau_d;
      v1_q <= iss;
      f1_q <= n_q == '0;
      l1_q <= n_q == NW'(MAX_TAU - 1);
      v2_q <= run && v1_q;
      f2_q <= f1_q;
      l2_q <= l1_q;
      prod_q <= qa * qb;
      acc_q <= acc_d;
      neg_q <= neg_d;
      pk_v_q <= pk_v_d;
      pk_q <= pk_d;
      pk_lag_q <= pk_lag_d;
      period_q <= period_d;
    end
  end
endmodule

// File: tb/tb_auto_corr.sv
// tb_auto_corr: randomized frames checked against an integer autocorrelation reference model.
module tb_auto_corr;
  localparam int DW = 12;
  localparam int MT = 32;
  localparam int BUDGET = (MT + 1) * (MT + 4);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic adc_clk = 1'b0;
  logic en = 1'b0;
  logic stable = 1'b0;
  logic signed [DW-1:0] data_in = '0;
  logic [15:0] period;

  int n_tests = 0;
  int n_fail = 0;
  int exp_period = 0;
  int prev_res = 0;
  int smp[$];

  auto_corr #(.DATA_WIDTH(DW), .MAX_TAU(MT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .adc_clk(adc_clk),
    .en     (en),
    .data_in(data_in),
    .stable (stable),
    .period (period)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_tests++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strike(input bit e, input int v);
    en = e;
    data_in = DW'(v);
    adc_clk = 1'b1;
    tick(3);
    adc_clk = 1'b0;
    tick(3);
  endtask

  function automatic int gen(input int kind, input int per, input int amp, input int i);
    int s;
    s = int'(amp * $sin(6.283185307179586 * real'(i) / real'(per)));
    if (kind == 1) return 0;
    if (kind == 2) return int'($urandom_range(0, 4000)) - 2000;
    if (kind == 3) return s + int'($urandom_range(0, 100)) - 50;
    return s;
  endfunction

  // R(tau) over the recorded frame, first negative lag, then the strictly-largest positive R after it
  function automatic int model();
    longint r[MT+1];
    longint best;
    int first, lag;
    for (int t = 0; t <= MT; t++) begin
      r[t] = 0;
      for (int n = 0; n < MT; n++) r[t] += longint'(smp[n]) * longint'(smp[n + t]);
    end
    first = -1;
    for (int t = 1; t <= MT && first < 0; t++) if (r[t] < 0) first = t;
    if (first < 0) return 0;
    best = 0;
    lag = 0;
    for (int t = first + 1; t <= MT; t++) if (r[t] > best) begin
      best = r[t];
      lag = t;
    end
    return lag;
  endfunction

  task automatic feed(input int kind, input int per, input int amp, input bit gate, input int cnt);
    int i = 0;
    int v;
    smp.delete();
    while (i < cnt) begin
      if (gate && $urandom_range(0, 1) == 0) strike(1'b0, int'($urandom_range(0, 4000)) - 2000);
      else begin
        v = gen(kind, per, amp, i);
        smp.push_back(v);
        strike(1'b1, v);
        i++;
      end
    end
    en = 1'b0;
  endtask

  task automatic frame(input string tag, input int kind, input int per, input int amp, input bit gate);
    int res;
    feed(kind, per, amp, gate, 2 * MT);
    tick(BUDGET / 2);
    check({tag, "_hold"}, period, exp_period);
    tick(BUDGET - BUDGET / 2);
    res = model();
`ifdef AUTOCORR_CONFIRM_EN
    if (res == 0 || (res >= prev_res - 1 && res <= prev_res + 1)) exp_period = res;
    prev_res = res;
`else
    exp_period = res;
`endif
    check(tag, period, exp_period);
  endtask

  initial begin
    int per;
    rst_n = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 8; i++) strike(1'b1, gen(0, 16, 500, i));
    check("rst_period", period, 0);
    rst_n = 1'b1;
    stable = 1'b0;
    tick(3);
    check("idle_period", period, 0);
    stable = 1'b1;
    tick(3);
    frame("sine16", 0, 16, 500, 1'b0);
    frame("sine25", 0, 25, 500, 1'b0);
    frame("sine32_lastlag", 0, 32, 500, 1'b0);
    frame("sine64", 0, 64, 500, 1'b0);
    frame("zero", 1, 16, 0, 1'b0);
    frame("gate16", 0, 16, 500, 1'b1);
    frame("sine20", 0, 20, 900, 1'b0);
    feed(0, 16, 500, 1'b0, 40);
    stable = 1'b0;
    tick(4);
    check("abort_fill", period, exp_period);
    stable = 1'b1;
    tick(3);
    frame("after_abort_fill", 0, 25, 700, 1'b0);
    feed(0, 16, 500, 1'b0, 2 * MT);
    tick(200);
    stable = 1'b0;
    tick(4);
    check("abort_calc", period, exp_period);
    stable = 1'b1;
    tick(3);
    frame("after_abort_calc", 0, 16, 600, 1'b0);
    feed(0, 20, 500, 1'b0, 30);
    #1 rst_n = 1'b0;
    #1 check("async_rst", period, 0);
    exp_period = 0;
    prev_res = 0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    frame("after_rst", 0, 24, 800, 1'b0);
    for (int k = 0; k < 8; k++) begin
      per = ($urandom_range(0, 3) == 0) ? 64 : int'($urandom_range(8, 32));
      frame($sformatf("rnd%0d", k), int'($urandom_range(0, 3)), per,
            int'($urandom_range(100, 1900)), 1'($urandom_range(0, 1)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/auto_corr.md
AUTO_CORR -- requirements
Module: auto_corr

Interface
REQ-001 Parameter DATA_WIDTH, default 12: sample width, two's complement.
REQ-002 Parameter MAX_TAU, default 256: largest lag searched; power of two, >=8.
REQ-003 clk  input  1  system clock, 200 MHz nominal; the only clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 adc_clk  input  1  ADC strobe, ~10 MHz; treated as a data signal and sampled in clk.
REQ-006 en  input  1  high = data_in valid (DC-removed data from upstream).
REQ-007 data_in  input  DATA_WIDTH signed  sample; changes on adc_clk falling edge.
REQ-008 stable  input  1  high = upstream settled, measurement allowed.
REQ-009 period  output  16  detected period in samples; 0 = none detected.

Function
REQ-010 adc_clk SHALL pass a 2-flop synchronizer; a rising edge detected after it marks a sample strike.
REQ-011 States SHALL be IDLE, FILL, CALC, DONE; IDLE->FILL when stable=1.
REQ-012 In FILL, each sample strike with en=1 SHALL write data_in to buffer address wr_cnt and increment wr_cnt; strikes with en=0 write nothing and hold wr_cnt.
REQ-013 FILL->CALC when wr_cnt reaches 2*MAX_TAU; strikes during CALC/DONE SHALL be ignored (non-overlapping frames).
REQ-014 CALC SHALL compute R(tau) = sum over n=0..MAX_TAU-1 of x[n]*x[n+tau], for tau = 0..MAX_TAU inclusive, one MAC per clk, lags in ascending order.
REQ-015 Products SHALL be signed full width (2*DATA_WIDTH); accumulator ACC_W = 2*DATA_WIDTH + clog2(MAX_TAU) + 1 bits; no saturation required.
REQ-016 Peak search: after R(tau) first goes below 0 (tau>=1), track the maximum R and its lag for all later lags; ties keep the smaller lag.
REQ-017 If R never goes negative, or the tracked maximum is <=0, the result SHALL be 0.
REQ-018 CALC->DONE after lag MAX_TAU; in DONE, period SHALL load the result for one cycle, then ->FILL with wr_cnt=0 if stable=1, else ->IDLE.
REQ-019 period SHALL be updated no later than (MAX_TAU+1)*(MAX_TAU+4) clk after the last frame sample is written.
REQ-020 stable=0 in FILL or CALC SHALL abort to IDLE next clk: wr_cnt, accumulator and peak tracker cleared; period holds.
REQ-021 period SHALL change only in DONE.

Reset
REQ-022 rst_n=0 SHALL force IDLE, wr_cnt=0, accumulator=0, synchronizer flops=0, period=0, all asynchronously.
REQ-023 A reset mid-frame discards the frame; the first frame after release starts at buffer address 0.

Configuration
REQ-024 Macro AUTOCORR_CONFIRM_EN defined: period loads a new nonzero result only if it is within +/-1 of the previous frame's result (stored internally, reset 0); a 0 result always loads.
REQ-025 AUTOCORR_CONFIRM_EN undefined: every frame result loads period directly.

Structure
REQ-026 Package autocorr_pkg SHALL hold the state enum, the ACC_W computation function and the lag/counter width constants.
REQ-027 Sub-module autocorr_buf: 2*MAX_TAU x DATA_WIDTH RAM, one write port, two registered read ports (x[n], x[n+tau]), read latency 1.
REQ-028 Top holds FSM, synchronizer, pipelined MAC (read, multiply, accumulate) and peak tracker.

Verification
REQ-029 Reset asserted with stable=1 and sine applied -> period=0, state IDLE, no writes.
REQ-030 Sine amplitude 500 codes, period 128 samples, en=stable=1 -> period=128+/-1 after first frame.
REQ-031 Sine amplitude 500, period 200 -> period=200+/-1; then period 256 -> period=256 (last-lag boundary).
REQ-032 Sine period 512, then constant 0 input -> period=0 both cases.
REQ-033 stable dropped at wr_cnt=300, raised again -> period unchanged; next frame refills from 0 and reports correctly.
REQ-034 en toggled 50% during FILL with sine period 128 per valid sample -> still 128+/-1; with AUTOCORR_CONFIRM_EN, alternating periods 128/200 frames -> period holds first confirmed value.
